// File: rtl/prco_ctrl.sv
// prco_ctrl: multi-cycle fetch/decode/exec/mem/wb sequencer; PRCO_CTRL_PERF_EN adds instret/cycle counters
module prco_ctrl #(
    parameter int          MEM_LAT  = 1,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [5:0]  HALT_OP  = 6'h3F
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    input  logic [15:0] i_mem_douta,
    input  logic [5:0]  i_dec_op,
    input  logic        i_mem_op,
    input  logic        i_mem_wr,
    input  logic [15:0] i_data_addr,
    input  logic        i_wb_en,
    input  logic        i_br_taken,
    input  logic [15:0] i_br_target,
    input  logic        i_halt_req,
    input  logic        i_resume,
    output logic [5:0]  q_state,
    output logic [15:0] q_pc,
    output logic [15:0] q_ir,
    output logic [15:0] q_mdr,
    output logic [15:0] q_mem_addr,
    output logic        q_mem_re,
    output logic        q_mem_we,
    output logic        q_dec_en,
    output logic        q_alu_en,
    output logic        q_reg_we,
    output logic [31:0] q_instret,
    output logic [31:0] q_cycles
);
    typedef enum logic [5:0] {
        FETCH  = 6'h01,
        DECODE = 6'h02,
        EXEC   = 6'h04,
        MEM    = 6'h08,
        WB     = 6'h10,
        HALT   = 6'h20
    } state_t;
    localparam logic [1:0] LAST = 2'(MEM_LAT);
    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [1:0]  lat_q, lat_d;
    logic        last, is_halt, on;
    assign last    = lat_q == LAST;
    assign is_halt = i_dec_op == HALT_OP;
    assign on      = i_en & i_reset_n;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        lat_d   = lat_q;
        if (i_en) begin
            case (state_q)
                FETCH: begin
                    lat_d   = last ? 2'd0 : lat_q + 2'd1;
                    ir_d    = last ? i_mem_douta : ir_q;
                    state_d = last ? DECODE : FETCH;
                end
                DECODE: state_d = EXEC;
                EXEC: begin
                    pc_d    = is_halt ? pc_q + 16'd1 : pc_q;
                    state_d = is_halt ? HALT : i_mem_op ? MEM : WB;
                end
                MEM: begin
                    lat_d   = last ? 2'd0 : lat_q + 2'd1;
                    mdr_d   = (last && !i_mem_wr) ? i_mem_douta : mdr_q;
                    state_d = last ? WB : MEM;
                end
                WB: begin
                    pc_d    = i_br_taken ? i_br_target : pc_q + 16'd1;
                    state_d = i_halt_req ? HALT : FETCH;
                end
                HALT: state_d = (i_resume && !i_halt_req) ? FETCH : HALT;
                default: state_d = FETCH;
            endcase
        end
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0;
            mdr_q   <= 16'h0;
            lat_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            lat_q   <= lat_d;
        end
    end
    assign q_state    = state_q;
    assign q_pc       = pc_q;
    assign q_ir       = ir_q;
    assign q_mdr      = mdr_q;
    assign q_mem_addr = state_q == FETCH ? pc_q : state_q == MEM ? i_data_addr : 16'h0;
    assign q_mem_re   = on & ((state_q == FETCH) | ((state_q == MEM) & ~i_mem_wr));
    assign q_mem_we   = on & (state_q == MEM) & i_mem_wr;
    assign q_dec_en   = on & (state_q == DECODE);
    assign q_alu_en   = on & (state_q == EXEC);
    assign q_reg_we   = on & (state_q == WB) & i_wb_en;
`ifdef PRCO_CTRL_PERF_EN
    logic [31:0] instret_q, instret_d, cycles_q, cycles_d;
    logic        retire;
    assign retire = i_en & ((state_q == WB) | ((state_q == EXEC) & is_halt));
    always_comb begin
        instret_d = instret_q + 32'(retire);
        cycles_d  = cycles_q + 32'(i_en && state_q != HALT);
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            instret_q <= 32'h0;
            cycles_q  <= 32'h0;
        end else begin
            instret_q <= instret_d;
            cycles_q  <= cycles_d;
        end
    end
    assign q_instret = instret_q;
    assign q_cycles  = cycles_q;
`else
    assign q_instret = 32'h0;
    assign q_cycles  = 32'h0;
`endif
endmodule

// File: tb/tb_prco_ctrl.sv
// tb_prco_ctrl: directed and random instruction sequences checked against a phase-list model of the sequencer
module tb_prco_ctrl;
    localparam int          LAT      = 1;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [5:0]  HALT_OP  = 6'h3F;
    localparam logic [5:0]  FETCH = 6'h01, DECODE = 6'h02, EXEC = 6'h04, MEM = 6'h08, WB = 6'h10, HALT = 6'h20;
    logic        i_clk, i_reset_n, i_en, i_mem_op, i_mem_wr, i_wb_en, i_br_taken, i_halt_req, i_resume;
    logic [15:0] i_mem_douta, i_data_addr, i_br_target;
    logic [5:0]  i_dec_op;
    logic [5:0]  q_state;
    logic [15:0] q_pc, q_ir, q_mdr, q_mem_addr;
    logic        q_mem_re, q_mem_we, q_dec_en, q_alu_en, q_reg_we;
    logic [31:0] q_instret, q_cycles;
    logic [15:0] mpc, mmdr;
    logic [31:0] minstret, mcycles;
    int          n_assert = 0, n_fail = 0;
    prco_ctrl #(.MEM_LAT(LAT), .RESET_PC(RESET_PC), .HALT_OP(HALT_OP)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en), .i_mem_douta(i_mem_douta),
        .i_dec_op(i_dec_op), .i_mem_op(i_mem_op), .i_mem_wr(i_mem_wr), .i_data_addr(i_data_addr),
        .i_wb_en(i_wb_en), .i_br_taken(i_br_taken), .i_br_target(i_br_target),
        .i_halt_req(i_halt_req), .i_resume(i_resume), .q_state(q_state), .q_pc(q_pc),
        .q_ir(q_ir), .q_mdr(q_mdr), .q_mem_addr(q_mem_addr), .q_mem_re(q_mem_re),
        .q_mem_we(q_mem_we), .q_dec_en(q_dec_en), .q_alu_en(q_alu_en), .q_reg_we(q_reg_we),
        .q_instret(q_instret), .q_cycles(q_cycles)
    );
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return a == 16'h0000 ? 16'h1234 : a == 16'h0100 ? 16'hBEEF : (a * 16'h9E37) ^ 16'h5A5A;
    endfunction
    always @(posedge i_clk) i_mem_douta <= mem_f(q_mem_addr);
    function automatic logic [63:0] exp_cnt();
`ifdef PRCO_CTRL_PERF_EN
        return {minstret, mcycles};
`else
        return 64'h0;
`endif
    endfunction
    task automatic ck(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic chk(input string tag, input logic [5:0] st, input logic [15:0] ad, input logic [4:0] sb, input bit ret);
        #1;
        ck(tag, {q_state, q_pc, q_mem_addr, q_mem_re, q_mem_we, q_dec_en, q_alu_en, q_reg_we},
           {st, mpc, ad, i_en ? sb : 5'b0});
        ck({tag, "_cnt"}, {q_instret, q_cycles}, exp_cnt());
        if (i_en && st != HALT) mcycles++;
        if (i_en && ret) minstret++;
        @(negedge i_clk);
    endtask
    task automatic model_reset();
        mpc = RESET_PC;
        mmdr = 16'h0;
        minstret = 0;
        mcycles = 0;
    endtask
    task automatic run_instr(input logic [5:0] op, input logic mop, input logic mwr, input logic wbe,
                             input logic br, input logic [15:0] tgt, input logic [15:0] dad,
                             input logic hr, input int hold, input bit stall, input bit abort);
        logic [15:0] pc;
        pc = mpc;
        i_dec_op = op; i_mem_op = mop; i_mem_wr = mwr; i_wb_en = wbe;
        i_br_taken = br; i_br_target = tgt; i_data_addr = dad; i_halt_req = hr; i_resume = 1'b0;
        for (int k = 0; k <= LAT; k++) chk("fetch", FETCH, pc, 5'b10000, 0);
        ck("ir", {48'h0, q_ir}, {48'h0, mem_f(pc)});
        chk("decode", DECODE, 16'h0, 5'b00100, 0);
        if (op == HALT_OP) begin
            chk("exec_halt", EXEC, 16'h0, 5'b00010, 1);
            mpc = pc + 16'd1;
        end else begin
            chk("exec", EXEC, 16'h0, 5'b00010, 0);
            if (mop) begin
                for (int k = 0; k <= LAT; k++) begin
                    if (k == 0 && stall) begin
                        i_en = 1'b0;
                        repeat (3) chk("stall", MEM, dad, 5'b0, 0);
                        i_en = 1'b1;
                    end
                    if (k == 0 && abort) begin
                        #1 i_reset_n = 1'b0;
                        #1;
                        ck("rst_async", {q_state, q_pc, q_ir, q_mdr, q_mem_re, q_mem_we, q_dec_en, q_alu_en, q_reg_we},
                           {FETCH, RESET_PC, 16'h0, 16'h0, 5'b0});
                        @(negedge i_clk);
                        i_reset_n = 1'b1;
                        model_reset();
                        return;
                    end
                    chk("mem", MEM, dad, {~mwr, mwr, 3'b0}, 0);
                end
                if (!mwr) mmdr = mem_f(dad);
            end
            ck("mdr", {48'h0, q_mdr}, {48'h0, mmdr});
            chk("wb", WB, 16'h0, {4'b0, wbe}, 1);
            mpc = br ? tgt : pc + 16'd1;
        end
        if (op == HALT_OP || hr) begin
            repeat (hold) chk("halt", HALT, 16'h0, 5'b0, 0);
            i_resume = 1'b1;
            i_halt_req = 1'b1;
            chk("halt_req_hold", HALT, 16'h0, 5'b0, 0);
            i_halt_req = 1'b0;
            chk("resume", HALT, 16'h0, 5'b0, 0);
            i_resume = 1'b0;
        end
    endtask
    initial begin
        logic [5:0] op;
        i_reset_n = 1'b0; i_en = 1'b1; i_dec_op = 6'h0; i_mem_op = 1'b0; i_mem_wr = 1'b0;
        i_wb_en = 1'b0; i_br_taken = 1'b0; i_br_target = 16'h0; i_data_addr = 16'h0;
        i_halt_req = 1'b0; i_resume = 1'b0;
        model_reset();
        repeat (2) @(negedge i_clk);
        #1;
        ck("reset", {q_state, q_pc, q_ir, q_mdr, q_mem_re, q_mem_we, q_dec_en, q_alu_en, q_reg_we},
           {FETCH, RESET_PC, 16'h0, 16'h0, 5'b0});
        ck("reset_cnt", {q_instret, q_cycles}, 64'h0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        run_instr(6'h01, 0, 0, 1, 0, 16'h0, 16'h0, 0, 0, 0, 0);
        run_instr(6'h02, 0, 0, 0, 1, 16'h0040, 16'h0, 0, 0, 0, 0);
        run_instr(6'h03, 0, 0, 1, 1, 16'hFFFF, 16'h0, 0, 0, 0, 0);
        run_instr(6'h04, 0, 0, 1, 0, 16'h1111, 16'h0, 0, 0, 0, 0);
        run_instr(6'h05, 1, 0, 1, 0, 16'h0, 16'h0100, 0, 0, 0, 0);
        run_instr(6'h06, 1, 1, 0, 1, 16'h0005, 16'h0200, 0, 0, 0, 0);
        run_instr(HALT_OP, 1, 0, 1, 0, 16'h0, 16'h0300, 0, 100, 0, 0);
        run_instr(6'h07, 1, 0, 1, 0, 16'h0, 16'h0333, 0, 0, 1, 0);
        run_instr(6'h08, 1, 0, 1, 0, 16'h0, 16'h0100, 1, 2, 0, 0);
        run_instr(6'h09, 1, 0, 1, 0, 16'h0, 16'h0444, 0, 0, 0, 1);
        run_instr(6'h0A, 0, 0, 1, 0, 16'h0, 16'h0, 0, 0, 0, 0);
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 7) == 0) ? HALT_OP : 6'($urandom_range(0, 62));
            run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 3),
                      $urandom_range(0, 5) == 0, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
